aes_uart_host: RTL and testbench

AES_UART_HOST -- requirements
Module: aes_uart_host

---
 rtl/aes_uart_host_pkg.sv | 15 +
 rtl/serial_rx.sv | 93 +++++++++
 rtl/serial_tx.sv | 92 +++++++++
 rtl/aes_uart_host.sv | 141 ++++++++++++++
 tb/tb_aes_uart_host.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_uart_host_pkg.sv
// Shared frame lengths and host FSM encoding for the AES UART host.
package aes_uart_host_pkg;

  localparam int unsigned REQ_BYTES = 48;
  localparam int unsigned RSP_BYTES = 16;

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StWaitTx,
    StRecv,
    StDone
  } host_state_e;

endpackage

// File: rtl/serial_rx.sv
// 8N1 UART receiver; samples each bit at its centre and pulses new_data_o after the stop bit centre.
module serial_rx #(
  parameter int unsigned CLK_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       new_data_o
);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  localparam int unsigned CtrW = $clog2(CLK_PER_BIT + 1);
  localparam logic [CtrW-1:0] BitEnd  = CtrW'(CLK_PER_BIT - 1);
  localparam logic [CtrW-1:0] HalfBit = CtrW'(CLK_PER_BIT / 2 - 1);

  rx_state_e       state_q, state_d;
  logic [CtrW-1:0] ctr_q, ctr_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      data_q, data_d;
  logic            new_q, new_d;
  logic [1:0]      sync_q;
  logic            rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      state_q <= RxIdle;
      ctr_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      new_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      state_q <= state_d;
      ctr_q   <= ctr_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      new_q   <= new_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    bit_d   = bit_q;
    data_d  = data_q;
    new_d   = 1'b0;
    unique case (state_q)
      RxIdle: begin
        if (!rx_s) begin
          ctr_d   = '0;
          state_d = RxStart;
        end
      end
      RxStart: begin
        ctr_d = ctr_q + CtrW'(1);
        // A start bit that has gone high again by its centre was a glitch.
        if (ctr_q == HalfBit) begin
          ctr_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? RxIdle : RxData;
        end
      end
      RxData: begin
        ctr_d = ctr_q + CtrW'(1);
        if (ctr_q == BitEnd) begin
          ctr_d  = '0;
          bit_d  = bit_q + 3'd1;
          data_d = {rx_s, data_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = RxStop;
          end
        end
      end
      RxStop: begin
        ctr_d = ctr_q + CtrW'(1);
        if (ctr_q == BitEnd) begin
          new_d   = 1'b1;
          state_d = RxIdle;
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  assign data_o     = data_q;
  assign new_data_o = new_q;

endmodule

// File: rtl/serial_tx.sv
// 8N1 UART transmitter; one bit lasts CLK_PER_BIT clock cycles.
module serial_tx #(
  parameter int unsigned CLK_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       block_i,
  input  logic [7:0] data_i,
  input  logic       new_data_i,
  output logic       tx_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

  localparam int unsigned CtrW = $clog2(CLK_PER_BIT + 1);
  localparam logic [CtrW-1:0] BitEnd = CtrW'(CLK_PER_BIT - 1);

  tx_state_e       state_q, state_d;
  logic [CtrW-1:0] ctr_q, ctr_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      data_q, data_d;
  logic            tx_q, tx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TxIdle;
      ctr_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    bit_d   = bit_q;
    data_d  = data_q;
    tx_d    = tx_q;
    unique case (state_q)
      TxIdle: begin
        tx_d = 1'b1;
        if (new_data_i && !block_i) begin
          data_d  = data_i;
          ctr_d   = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
          state_d = TxStart;
        end
      end
      TxStart: begin
        ctr_d = ctr_q + CtrW'(1);
        if (ctr_q == BitEnd) begin
          ctr_d   = '0;
          tx_d    = data_q[0];
          state_d = TxData;
        end
      end
      TxData: begin
        ctr_d = ctr_q + CtrW'(1);
        if (ctr_q == BitEnd) begin
          ctr_d  = '0;
          bit_d  = bit_q + 3'd1;
          data_d = {1'b0, data_q[7:1]};
          tx_d   = data_q[1];
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = TxStop;
          end
        end
      end
      TxStop: begin
        ctr_d = ctr_q + CtrW'(1);
        if (ctr_q == BitEnd) begin
          state_d = TxIdle;
        end
      end
      default: state_d = TxIdle;
    endcase
  end

  assign tx_o   = tx_q;
  assign busy_o = block_i || (state_q != TxIdle);

endmodule

// File: rtl/aes_uart_host.sv
// Host that ships a 48-byte key+plaintext frame over UART and collects the 16-byte ciphertext reply.
module aes_uart_host
  import aes_uart_host_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned CLK_PER_BIT    = 100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] key_in,
  input  logic [127:0] text_in,
  output logic         busy,
  output logic [127:0] text_out,
  output logic         done,
  output logic         error,
  output logic         tx,
  input  logic         rx
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CYCLES - 1);

  host_state_e               state_q, state_d;
  logic [REQ_BYTES-1:0][7:0] shadow_q, shadow_d;
  logic [RSP_BYTES-1:0][7:0] text_q, text_d;
  logic [5:0]                tx_cnt_q, tx_cnt_d;
  logic [4:0]                rx_cnt_q, rx_cnt_d;
  logic [TimerW-1:0]         timer_q, timer_d;
  logic                      error_q, error_d;

  logic       tx_busy;
  logic       tx_new;
  logic [7:0] tx_byte;
  logic       rx_new;
  logic [7:0] rx_byte;

  serial_tx #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_serial_tx (
    .clk       (clk),
    .rst       (rst),
    .block_i   (1'b0),
    .data_i    (tx_byte),
    .new_data_i(tx_new),
    .tx_o      (tx),
    .busy_o    (tx_busy)
  );

  serial_rx #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_serial_rx (
    .clk       (clk),
    .rst       (rst),
    .rx_i      (rx),
    .data_o    (rx_byte),
    .new_data_o(rx_new)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      shadow_q <= '0;
      text_q   <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      timer_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      text_q   <= text_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      timer_q  <= timer_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    text_d   = text_q;
    tx_cnt_d = tx_cnt_q;
    rx_cnt_d = rx_cnt_q;
    timer_d  = timer_q;
    error_d  = error_q;
    tx_new   = 1'b0;
    tx_byte  = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          shadow_d = {text_in, key_in};
          tx_cnt_d = '0;
          rx_cnt_d = '0;
          timer_d  = '0;
          error_d  = 1'b0;
          state_d  = StSend;
        end
      end
      StSend: begin
        if (!tx_busy) begin
          tx_new   = 1'b1;
          tx_byte  = shadow_q[tx_cnt_q];
          tx_cnt_d = tx_cnt_q + 6'd1;
          state_d  = StWaitTx;
        end
      end
      StWaitTx: begin
        // The transmitter raises busy on the edge that accepts the byte, so this
        // state always lasts at least one cycle.
        if (!tx_busy) begin
          state_d = (tx_cnt_q < 6'(REQ_BYTES)) ? StSend : StRecv;
        end
      end
      StRecv: begin
        if (rx_new) begin
          text_d[rx_cnt_q[3:0]] = rx_byte;
          rx_cnt_d = rx_cnt_q + 5'd1;
          timer_d  = '0;
          if (rx_cnt_q == 5'(RSP_BYTES - 1)) begin
            state_d = StDone;
          end
        end else if (timer_q == TimerMax) begin
          error_d = 1'b1;
          state_d = StDone;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign error    = error_q;
  assign text_out = text_q;

endmodule

// File: tb/tb_aes_uart_host.sv
// Randomised self-checking bench: UART frame monitor, target responder and a byte-level result model.
module tb_aes_uart_host;

  localparam int unsigned CPB = 8;
  localparam int unsigned TMO = 400;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         rx = 1'b1;
  logic [255:0] key_in = '0;
  logic [127:0] text_in = '0;
  logic         busy, done, error, tx;
  logic [127:0] text_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]   mon_q[$];
  logic [127:0] exp_text = '0;
  logic         exp_error = 1'b0;
  logic         expect_done = 1'b0;
  logic [383:0] exp_frame = '0;
  int           done_cnt = 0;

  aes_uart_host #(
    .TIMEOUT_CYCLES(TMO),
    .CLK_PER_BIT   (CPB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .key_in  (key_in),
    .text_in (text_in),
    .busy    (busy),
    .text_out(text_out),
    .done    (done),
    .error   (error),
    .tx      (tx),
    .rx      (rx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Per-cycle result check: done must be expected and carry the modelled result;
  // while idle the line is high and text_out holds the last modelled result.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        check("done_expected", expect_done, 1);
        check("done_error", error, exp_error);
        check("done_text", text_out, exp_text);
        check("done_busy", busy, 1);
        expect_done = 1'b0;
        done_cnt++;
      end else if (!busy) begin
        check("idle_tx", tx, 1);
        check("idle_text", text_out, exp_text);
      end
    end
  end

  initial begin : tx_monitor
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        check("tx_start_bit", tx, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        check("tx_stop_bit", tx, 1);
        mon_q.push_back(b);
      end
    end
  end

  initial begin : watchdog
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "bench watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic run_txn(input logic [255:0] k, input logic [127:0] t,
                         input logic [127:0] rsp, input int nrsp, input bit mid_start);
    int cyc;
    int lat;
    int prev_done;
    bit pulsed;
    mon_q.delete();
    prev_done = done_cnt;
    @(negedge clk);
    key_in  = k;
    text_in = t;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    exp_frame = {t, k};
    for (int i = 0; i < nrsp; i++) exp_text[8*i +: 8] = rsp[8*i +: 8];
    exp_error   = (nrsp < 16);
    expect_done = 1'b1;
    key_in  = {8{$urandom}};
    text_in = {4{$urandom}};
    lat = 0;
    while (tx !== 1'b0 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("start_latency", (lat <= 3) && (tx === 1'b0), 1);

    cyc = 0;
    pulsed = 1'b0;
    while (mon_q.size() < 48 && cyc < 48 * (10 * CPB + 8)) begin
      @(negedge clk);
      cyc++;
      if (mid_start && !pulsed && mon_q.size() >= 20) begin
        start   = 1'b1;
        key_in  = ~k;
        text_in = ~t;
        pulsed  = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    check("frame_len", mon_q.size(), 48);
    for (int i = 0; i < mon_q.size() && i < 48; i++)
      check($sformatf("frame_byte_%0d", i), mon_q[i], exp_frame[8*i +: 8]);

    repeat ($urandom_range(200, 5)) @(negedge clk);
    for (int i = 0; i < nrsp; i++) begin
      send_byte(rsp[8*i +: 8]);
      if (i < nrsp - 1) repeat ($urandom_range(60, 0)) @(negedge clk);
    end

    cyc = 0;
    while (done_cnt == prev_done && cyc < TMO + 4 * CPB) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", done_cnt - prev_done, 1);
    if (nrsp < 16) check("timeout_window", (cyc >= TMO - CPB) && (cyc <= TMO + 2 * CPB), 1);
    else check("done_latency", cyc <= 3 * CPB, 1);
    repeat (20 * CPB) @(negedge clk);
    check("single_done", done_cnt - prev_done, 1);
    check("busy_after_done", busy, 0);
    check("no_extra_tx", mon_q.size(), 48);
  endtask

  initial begin : main
    logic [255:0] fk;
    logic [127:0] ft;
    logic [127:0] rsp;
    int           cyc;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_text_out", text_out, 0);
    check("rst_tx", tx, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (5) @(negedge clk);

    // FIPS-197 AES-256 vector; the responder plays the AES target.
    for (int i = 0; i < 32; i++) fk[8*i +: 8] = 8'(i);
    for (int i = 0; i < 16; i++) ft[8*i +: 8] = 8'(i * 17);
    run_txn(fk, ft, 128'h8960494b_9049fcea_bf456751_cab7a28e, 16, 1'b0);
    check("fips_text_out", text_out, 128'h8960494b_9049fcea_bf456751_cab7a28e);
    check("fips_error", error, 0);
    check("fips_byte0", mon_q[0], 8'h00);
    check("fips_byte31", mon_q[31], 8'h1f);
    check("fips_byte33", mon_q[33], 8'h11);
    check("fips_byte47", mon_q[47], 8'hff);

    for (int n = 0; n < 2; n++) begin
      rsp = {4{$urandom}};
      run_txn({8{$urandom}}, {4{$urandom}}, rsp, 16, 1'b0);
    end

    rsp = {4{$urandom}};
    run_txn({8{$urandom}}, {4{$urandom}}, rsp, 16, 1'b1);

    // Stray byte while idle must leave text_out and the next reply untouched.
    send_byte(8'hAA);
    repeat (4 * CPB) @(negedge clk);
    check("stray_text_out", text_out, exp_text);
    rsp = {4{$urandom}};
    run_txn({8{$urandom}}, {4{$urandom}}, rsp, 16, 1'b0);

    // Short reply: ten bytes then silence.
    rsp = {4{$urandom}};
    run_txn({8{$urandom}}, {4{$urandom}}, rsp, 10, 1'b0);
    check("timeout_error", error, 1);
    check("timeout_low_bytes", text_out[79:0], rsp[79:0]);

    // Reset in the middle of request byte 30, then a clean transaction.
    mon_q.delete();
    @(negedge clk);
    key_in  = {8{$urandom}};
    text_in = {4{$urandom}};
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (mon_q.size() < 30 && cyc < 40 * 10 * CPB) begin
      @(negedge clk);
      cyc++;
    end
    check("pre_reset_bytes", mon_q.size(), 30);
    repeat (40) @(negedge clk);
    #2;
    rst         = 1'b1;
    expect_done = 1'b0;
    exp_text    = '0;
    exp_error   = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_tx", tx, 1);
    check("async_rst_text", text_out, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    rsp = {4{$urandom}};
    run_txn({8{$urandom}}, {4{$urandom}}, rsp, 16, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
